resource_arbiter: RTL and testbench
===================================

Name: resource_arbiter

Overview:
Shared-resource arbiter sitting directly downstream of the per-pipeline request/grant interface (arbiter_req / arbiter_grant / resource_input). It grants one of N_REQ pipelines at a time in round-robin order and forwards that pipeline's data to the shared resource. It tracks in-flight operations through a fixed-latency tag pipeline so that each resource result is returned to the requester that issued it. The grant output drives each pipeline's stall (stall = ~grant), so grant is registered and glitch-free.

Parameters:
N_REQ, 4, number of requesting pipelines (>=2)
DATA_W, 32, data width of request and result buses
HOLD_MAX, 8, maximum consecutive grant cycles to one owner while others are waiting
RES_LAT, 2, fixed resource latency in cycles from res_in_valid to result (>=1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req  input  N_REQ  per-pipeline arbiter_req
req_data  input  N_REQ*DATA_W  per-pipeline resource_input; slice i = bits [i*DATA_W +: DATA_W]
grant  output  N_REQ  one-hot or zero registered grant; drives each pipeline's arbiter_grant
res_in  output  DATA_W  data to shared resource
res_in_valid  output  1  res_in carries a live operation this cycle
res_out  input  DATA_W  shared resource result, valid RES_LAT cycles after issue
rsp_data  output  DATA_W  res_out broadcast to all pipelines (resource_output)
rsp_valid  output  N_REQ  one-hot: result on rsp_data belongs to pipeline i
rsp_tag  output  $clog2(N_REQ)  index of rsp_data owner (debug/scoreboard)

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, owner=0, rr_ptr=0, hold_cnt=0, all tag-pipe valids=0; hence res_in_valid=0, rsp_valid=0, rsp_tag=0. res_in = 0 while no grant.
- States: IDLE (no owner), BUSY (owner holds grant).
- Winner selection (combinational): first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
- IDLE: if |req, next cycle grant = onehot(winner), owner=winner, hold_cnt=0, go BUSY. Latency req->grant = 1 cycle. No req: stay IDLE.
- BUSY, each cycle:
  - req[owner]=1 and (hold_cnt < HOLD_MAX-1 or no other req): keep grant; hold_cnt++ (saturates, resets to 0 when no other req).
  - req[owner]=0, or hold_cnt = HOLD_MAX-1 with another req pending: release. rr_ptr <= owner+1 mod N_REQ. If another requester (excluding owner) is pending, switch grant directly to it next cycle (zero-bubble handoff, hold_cnt=0). Otherwise grant=0 and go IDLE.
- grant is never more than one-hot. A release and a new grant never overlap.
- Data path (combinational from registered owner): res_in = req_data[owner]; res_in_valid = grant[owner] & req[owner]. A grant cycle where the owner drops req issues nothing.
- Tag pipe: RES_LAT stages of {valid, owner}. Stage 0 loads {res_in_valid, owner} each cycle. rsp_valid = onehot(last.owner) when last.valid, else 0. rsp_tag = last.owner. rsp_data = res_out, unregistered.
- Results are delivered in issue order. The tag pipe is not stalled; the resource accepts one op per cycle.
- Reset mid-operation: in-flight tags are discarded and no rsp_valid is generated for them. Grant drops immediately (async).
- Simultaneous req rise from all N_REQ in IDLE after reset: pipeline 0 wins, then 1, 2, 3 in order as each releases.

Test Plan:
- Single requester: req=4'b0010 from cycle 0 with data 0xA5A5_0001, RES_LAT=2 -> grant=4'b0010 at cycle 1; res_in_valid=1 at cycle 1; rsp_valid=4'b0010, rsp_tag=1 at cycle 3.
- Round-robin: req=4'b1111 held -> grant sequence 0001 (8 cyc), 0010 (8), 0100 (8), 1000 (8), 0001 ... with no idle cycle between owners.
- Voluntary release: owner 2 drops req after 3 cycles while req[0]=1 -> grant moves to 0001 on the next cycle; rr_ptr=3, so a later simultaneous req[0], req[3] goes to 3 first.
- Hold limit with no contention: only req[3]=1 for 20 cycles -> grant stays 1000 for all 20 cycles, with continuous res_in_valid.
- Result routing: alternate owners 0 and 1 with distinct res_out stimulus (res_out = issued data + 1) -> each rsp_valid bit matches its issuer RES_LAT cycles later; the scoreboard sees zero mismatches.
- Reset mid-operation: assert reset=0 while grant=0100 with 2 ops in flight -> grant=0, rsp_valid=0 immediately. After release with req[1]=1 -> grant=0010 one cycle later; no stale rsp_valid appears.

Source files
------------

// File: rtl/resource_arbiter.sv
// resource_arbiter: round-robin grant of a shared fixed-latency resource with tag-routed results
module resource_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 8,
    parameter int RES_LAT  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic [DATA_W-1:0]         res_in,
    output logic                      res_in_valid,
    input  logic [DATA_W-1:0]         res_out,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [$clog2(N_REQ)-1:0]  rsp_tag
);
    localparam int TAG_W = $clog2(N_REQ);
    localparam int HC_W  = $clog2(HOLD_MAX + 1);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nx;
    logic [N_REQ-1:0]  grant_nx;
    logic [TAG_W-1:0]  owner, owner_nx;
    logic [TAG_W-1:0]  rr_ptr, rr_ptr_nx;
    logic [TAG_W-1:0]  next_ptr;
    logic [HC_W-1:0]   hold_cnt, hold_cnt_nx;
    logic [N_REQ-1:0]  others;
    logic              idle_hit, hand_hit, keep;
    logic [TAG_W-1:0]  idle_win, hand_win;
    logic              tag_v [RES_LAT];
    logic [TAG_W-1:0]  tag_o [RES_LAT];

    // In BUSY the grant vector is exactly the owner's one-hot, so masking it out leaves the contenders
    assign others   = req & ~grant;
    assign next_ptr = (owner == TAG_W'(N_REQ - 1)) ? '0 : owner + TAG_W'(1);

    // Rotating priority scans: from rr_ptr for a fresh grant, from owner+1 for a direct handoff
    always_comb begin
        idle_hit = 1'b0;
        idle_win = '0;
        hand_hit = 1'b0;
        hand_win = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!idle_hit && req[(int'(rr_ptr) + k) % N_REQ]) begin
                idle_hit = 1'b1;
                idle_win = TAG_W'((int'(rr_ptr) + k) % N_REQ);
            end
            if (!hand_hit && others[(int'(next_ptr) + k) % N_REQ]) begin
                hand_hit = 1'b1;
                hand_win = TAG_W'((int'(next_ptr) + k) % N_REQ);
            end
        end
    end

    // Next-state: grant from IDLE, keep/limit/release in BUSY with zero-bubble handoff
    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        owner_nx    = owner;
        rr_ptr_nx   = rr_ptr;
        hold_cnt_nx = hold_cnt;
        keep        = req[owner] && ((hold_cnt < HOLD_LIM) || !(|others));
        if (state == IDLE) begin
            if (idle_hit) begin
                state_nx    = BUSY;
                grant_nx    = N_REQ'(1) << idle_win;
                owner_nx    = idle_win;
                hold_cnt_nx = '0;
            end
        end else if (keep) begin
            hold_cnt_nx = !(|others) ? '0 : (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + HC_W'(1);
        end else begin
            rr_ptr_nx   = next_ptr;
            hold_cnt_nx = '0;
            if (hand_hit) begin
                grant_nx = N_REQ'(1) << hand_win;
                owner_nx = hand_win;
            end else begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        end
    end

    // Arbitration state; grant is registered so downstream stalls never glitch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            hold_cnt <= hold_cnt_nx;
        end
    end

    assign res_in       = (|grant) ? req_data[owner*DATA_W +: DATA_W] : '0;
    assign res_in_valid = grant[owner] & req[owner];

    // Tag pipe mirrors the resource latency so each result finds its issuer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < RES_LAT; k++) begin
                tag_v[k] <= 1'b0;
                tag_o[k] <= '0;
            end
        end else begin
            tag_v[0] <= res_in_valid;
            tag_o[0] <= owner;
            for (int k = 1; k < RES_LAT; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_o[k] <= tag_o[k-1];
            end
        end
    end

    assign rsp_data  = res_out;
    assign rsp_tag   = tag_o[RES_LAT-1];
    assign rsp_valid = tag_v[RES_LAT-1] ? N_REQ'(1) << tag_o[RES_LAT-1] : '0;
endmodule

// File: tb/tb_resource_arbiter.sv
// tb_resource_arbiter: directed checks of grant order, hold limit, result routing and reset
module tb_resource_arbiter;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [N_REQ-1:0]         req = '0;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         grant;
    logic [DATA_W-1:0]        res_in;
    logic                     res_in_valid;
    logic [DATA_W-1:0]        res_out;
    logic [DATA_W-1:0]        rsp_data;
    logic [N_REQ-1:0]         rsp_valid;
    logic [1:0]               rsp_tag;
    logic [DATA_W-1:0]        m1 = '0, m2 = '0;
    int n_cmp = 0;
    int n_err = 0;

    resource_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .HOLD_MAX(8), .RES_LAT(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
        .res_in(res_in), .res_in_valid(res_in_valid), .res_out(res_out),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag)
    );

    always #5 clk = ~clk;

    // Two-cycle resource that returns its operand plus one
    always @(posedge clk) begin
        m1 <= res_in + 32'd1;
        m2 <= m1;
    end
    assign res_out = m2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_data();
        for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = 32'hD000_0000 + i;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        req = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic run_rr(input logic [3:0] r, input int n_own, input int cycles);
        int o, p;
        req = r;
        for (int c = 1; c <= cycles; c++) begin
            step();
            o = ((c - 1) / 8) % n_own;
            check("rr_grant", grant, 4'b1 << o);
            check("rr_issue", {res_in_valid, res_in}, {1'b1, 32'hD000_0000 + o});
            if (c >= 3) begin
                p = ((c - 3) / 8) % n_own;
                check("rr_rsp", {rsp_valid, rsp_tag, rsp_data}, {4'b1 << p, 2'(p), 32'hD000_0001 + p});
            end
        end
    endtask

    initial begin
        set_data();
        @(negedge clk);
        @(negedge clk);
        check("rst_grant", grant, 4'b0000);
        check("rst_outs", {res_in_valid, rsp_valid, rsp_tag, res_in}, '0);

        reset = 1'b1;
        req = 4'b0010;
        req_data[32 +: 32] = 32'hA5A5_0001;
        step();
        check("single_grant_c1", grant, 4'b0010);
        check("single_issue_c1", {res_in_valid, res_in}, {1'b1, 32'hA5A5_0001});
        check("single_rsp_c1", rsp_valid, 4'b0000);
        step();
        check("single_rsp_c2", rsp_valid, 4'b0000);
        step();
        check("single_rsp_c3", {rsp_valid, rsp_tag, rsp_data}, {4'b0010, 2'd1, 32'hA5A5_0002});
        req = 4'b0000;
        #1;
        check("drop_no_issue", {grant, res_in_valid}, {4'b0010, 1'b0});
        step();
        check("release_grant", grant, 4'b0000);
        check("release_rsp_c4", rsp_valid, 4'b0010);
        step();
        check("dropped_no_rsp", rsp_valid, 4'b0000);
        set_data();

        pulse_reset();
        run_rr(4'b1111, 4, 40);

        pulse_reset();
        req = 4'b0100;
        step();
        check("vol_grant_c1", grant, 4'b0100);
        req = 4'b0101;
        step();
        step();
        check("vol_grant_c3", grant, 4'b0100);
        req = 4'b0001;
        step();
        check("vol_handoff", {grant, res_in_valid}, {4'b0001, 1'b1});
        req = 4'b0000;
        step();
        check("vol_idle", grant, 4'b0000);
        req = 4'b1001;
        step();
        check("rrptr_pick3", grant, 4'b1000);

        req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            step();
            check("solo_hold", {grant, res_in_valid}, {4'b1000, 1'b1});
        end
        req = 4'b1001;
        for (int c = 0; c < 7; c++) step();
        check("limit_last", grant, 4'b1000);
        step();
        check("limit_switch", grant, 4'b0001);

        pulse_reset();
        run_rr(4'b0011, 2, 24);

        pulse_reset();
        req = 4'b0100;
        step();
        check("mid_grant_c1", grant, 4'b0100);
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_outs", {grant, rsp_valid, res_in_valid}, '0);
        req = 4'b0010;
        step();
        reset = 1'b1;
        step();
        check("post_rst_grant", {grant, rsp_valid}, {4'b0010, 4'b0000});
        step();
        check("post_rst_no_stale", rsp_valid, 4'b0000);
        step();
        check("post_rst_rsp", {rsp_valid, rsp_tag, rsp_data}, {4'b0010, 2'd1, 32'hD000_0002});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
